// File: rtl/data_memory_pkg.sv
// Shared datapath constants for the rv32i core and its data memory.
package data_memory_pkg;

  // Architectural register / data word width.
  localparam int XLEN = 32;

  // Data memory word address width and number of implemented words.
  localparam int DM_ADDR_W = 5;
  localparam int DM_DEPTH  = 32;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle datapath.
// Writes happen on the rising clock edge; reads are purely combinational.
// Every word is a flop with an asynchronous clear, so the array is fully
// defined as soon as reset is applied and never reads X afterwards.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = DM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addres,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd
);

  // Storage array; each element is driven by its own word register below.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // One register per word with its own write-enable decode. Addresses at or
  // beyond DEPTH match no word, so out-of-range writes are dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic             sel;
    logic [WIDTH-1:0] word_q;

    assign sel    = we && (addres == ADDR_W'(i));
    assign mem[i] = word_q;

    // Clear immediately on reset; otherwise capture wd when this word is addressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (sel) begin
        word_q <= wd;
      end
    end
  end : g_word

  // Read mux: select the addressed word, or 0 when no word matches.
  always_comb begin
    rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addres == ADDR_W'(i)) begin
        rd = mem[i];
      end
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random
// traffic, scored against a plain array model through an expectation queue.
module tb_data_memory;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] addres;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd;

  data_memory #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addres(addres),
    .wd    (wd),
    .rd    (rd)
  );

  typedef struct {
    string            name;
    int               addr;
    logic [WIDTH-1:0] exp;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference memory: what each word should hold according to the rules.
  logic [WIDTH-1:0] model [DEPTH];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for an address given the model contents.
  function automatic logic [WIDTH-1:0] model_read(input int a);
    if (a < DEPTH) return model[a];
    return '0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Queue an expectation for the current address; the monitor scores it.
  task automatic expect_rd(input string name);
    exp_t e;
    e.name = name;
    e.addr = int'(addres);
    e.exp  = model_read(int'(addres));
    exp_q.push_back(e);
    #1;
  endtask

  // Write one word: check the old value is still visible before the edge,
  // then the new value right after the edge.
  task automatic apply_stimulus(input int a, input logic [WIDTH-1:0] d, input string name);
    @(negedge clk);
    addres = ADDR_W'(a);
    wd     = d;
    we     = 1'b1;
    #1;
    expect_rd({name, "_pre"});
    @(posedge clk);
    #1;
    if (rst_n && a < DEPTH) model[a] = d;
    we = 1'b0;
    expect_rd({name, "_post"});
  endtask

  // Read-only access with a scrambled wd that must not matter.
  task automatic check_output(input int a, input string name);
    @(negedge clk);
    we     = 1'b0;
    addres = ADDR_W'(a);
    wd     = $urandom;
    #1;
    expect_rd(name);
  endtask

  // Monitor: score each expectation against rd as soon as it is queued.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      vectors++;
      if (rd !== e.exp) begin
        miscompares++;
        $display("[TB] FAIL %s addr=%0d rd=%h expected=%h", e.name, e.addr, rd, e.exp);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence.
  initial begin
    int drain;
    rst_n  = 1'b1;
    we     = 1'b0;
    addres = '0;
    wd     = '0;
    clear_model();

    // Asynchronous reset applied mid-cycle must clear rd immediately.
    #2;
    rst_n = 1'b0;
    #1;
    expect_rd("reset_async");
    addres = ADDR_W'(17);
    #1;
    expect_rd("reset_async_a17");
    @(negedge clk);
    rst_n = 1'b1;

    // Everything reads zero after reset.
    for (int a = 0; a < DEPTH; a++) check_output(a, "reset_sweep");

    // Basic write and readback.
    apply_stimulus(10, 32'h19, "wr10");
    apply_stimulus(15, 32'h21, "wr15");

    // Hold: only the written words are nonzero, wd changes are ignored.
    for (int a = 0; a < DEPTH; a++) check_output(a, "hold_sweep");

    // Combinational read without bypass of wd.
    apply_stimulus(3, 32'hDEADBEEF, "wr3");

    // Reset coincident with a write: reset wins and clears earlier words.
    @(negedge clk);
    we     = 1'b1;
    addres = ADDR_W'(7);
    wd     = 32'h55;
    rst_n  = 1'b0;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    expect_rd("rst_prio_held");
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    check_output(7, "rst_prio_a7");
    check_output(10, "rst_prio_a10");
    check_output(15, "rst_prio_a15");
    check_output(3, "rst_prio_a3");

    // Boundary addresses and overwrite.
    apply_stimulus(0, 32'hFFFFFFFF, "wr0_ones");
    apply_stimulus(31, 32'h80000001, "wr31");
    apply_stimulus(0, 32'h00000001, "rewr0");
    check_output(0, "bound_a0");
    check_output(31, "bound_a31");

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      int a;
      a = int'($urandom_range(DEPTH - 1, 0));
      if ($urandom_range(39, 0) == 0) begin
        @(negedge clk);
        addres = ADDR_W'(a);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        expect_rd("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else if ($urandom_range(1, 0) == 1) begin
        apply_stimulus(a, $urandom, "rand_wr");
      end else begin
        check_output(a, "rand_rd");
      end
    end

    // Let the monitor consume anything still queued.
    drain = 0;
    while (exp_q.size() != 0 && drain < 100) begin
      #1;
      drain++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_memory
